// File: rtl/ram_arbiter.sv
`default_nettype none
//==============================================================================
// ram_arbiter : round-robin arbiter giving two masters access to one RAM port
// Rev 1.0
//==============================================================================
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rw,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] c_wait_init = 3'(RD_LAT - 1);

  state_t            r_state, w_state_nxt;
  logic              r_ptr, w_ptr_nxt;
  logic              r_gnt, w_gnt_nxt;
  logic              w_sel;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic              r_ram_rw, w_ram_rw_nxt;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_nxt;
  logic              r_m0_ack, w_m0_ack_nxt;
  logic              r_m1_ack, w_m1_ack_nxt;
  logic [DATA_W-1:0] r_m0_rdata, w_m0_rdata_nxt;
  logic [DATA_W-1:0] r_m1_rdata, w_m1_rdata_nxt;
  logic              r_busy, w_busy_nxt;

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_sel           = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_ram_rw_nxt    = 1'b0;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_m0_ack_nxt    = 1'b0;
    w_m1_ack_nxt    = 1'b0;
    w_m0_rdata_nxt  = r_m0_rdata;
    w_m1_rdata_nxt  = r_m1_rdata;

    case (r_state)
      IDLE: begin
        if (m0_req || m1_req) begin
          // contention goes to the pointer, a lone requester always wins
          w_sel           = (m0_req && m1_req) ? r_ptr : m1_req;
          w_gnt_nxt       = w_sel;
          w_ram_rw_nxt    = w_sel ? m1_rw    : m0_rw;
          w_ram_addr_nxt  = w_sel ? m1_addr  : m0_addr;
          w_ram_wdata_nxt = w_sel ? m1_wdata : m0_wdata;
          w_state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        if (r_ram_rw) begin
          w_state_nxt  = DONE;
          w_m0_ack_nxt = ~r_gnt;
          w_m1_ack_nxt = r_gnt;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = c_wait_init;
        end
      end
      WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt  = DONE;
          w_m0_ack_nxt = ~r_gnt;
          w_m1_ack_nxt = r_gnt;
          if (r_gnt) w_m1_rdata_nxt = ram_rdata;
          else       w_m0_rdata_nxt = ram_rdata;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      DONE: begin
        w_ptr_nxt   = ~r_gnt;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_gnt       <= 1'b0;
      r_cnt       <= 3'd0;
      r_ram_rw    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_m0_ack    <= 1'b0;
      r_m1_ack    <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ram_rw    <= w_ram_rw_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_m0_ack    <= w_m0_ack_nxt;
      r_m1_ack    <= w_m1_ack_nxt;
      r_m0_rdata  <= w_m0_rdata_nxt;
      r_m1_rdata  <= w_m1_rdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign ram_rw    = r_ram_rw;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign m0_ack    = r_m0_ack;
  assign m1_ack    = r_m1_ack;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
//==============================================================================
// tb_ram_arbiter : randomized two-master traffic against a transaction model
// Rev 1.0
//==============================================================================
module tb_ram_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 3;
  localparam int N_TXN  = 30;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              m0_req = 1'b0, m0_rw = 1'b0, m1_req = 1'b0, m1_rw = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic              m0_ack, m1_ack, ram_rw, busy;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rw(ram_rw),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  // RAM behaviour: write on the clock edge, read data after RD_LAT clocks
  logic [DATA_W-1:0] ram_mem [8];
  logic [DATA_W-1:0] pipe    [RD_LAT];
  always @(posedge clock) begin
    if (ram_rw) ram_mem[ram_addr[2:0]] <= ram_wdata;
    pipe[0] <= ram_mem[ram_addr[2:0]];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[RD_LAT-1];

  typedef struct {
    bit          m;
    bit          rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          gnt_cyc;
    int          ack_cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mdl_e, mon_e;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          run_model = 1'b0;
  int          next_idle = 0;
  bit          ptr = 1'b0;
  logic [15:0] mdl_mem [8];
  logic [15:0] exp_rd  [2];
  bit          mon_busy, mon_rw, mon_access;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Transaction model: grant rule, latency formula and memory contents
  always @(negedge clock) begin
    if (run_model && !reset && cyc >= next_idle && (m0_req || m1_req)) begin
      mdl_e.m       = (m0_req && m1_req) ? ptr : m1_req;
      mdl_e.rw      = mdl_e.m ? m1_rw    : m0_rw;
      mdl_e.addr    = mdl_e.m ? m1_addr  : m0_addr;
      mdl_e.wdata   = mdl_e.m ? m1_wdata : m0_wdata;
      mdl_e.gnt_cyc = cyc;
      mdl_e.ack_cyc = cyc + 2 + (mdl_e.rw ? 0 : RD_LAT);
      mdl_e.rdata   = mdl_mem[mdl_e.addr[2:0]];
      if (mdl_e.rw) mdl_mem[mdl_e.addr[2:0]] = mdl_e.wdata;
      q.push_back(mdl_e);
      next_idle = mdl_e.ack_cyc + 1;
      ptr       = ~mdl_e.m;
    end
  end

  // Monitor: checks RAM-side activity and pops expectations on each ack
  always @(negedge clock) begin
    if (run_model && !reset) begin
      mon_busy   = 1'b0;
      mon_access = 1'b0;
      mon_rw     = 1'b0;
      if (q.size() > 0) begin
        mon_busy   = (cyc > q[0].gnt_cyc) && (cyc <= q[0].ack_cyc);
        mon_access = (cyc == q[0].gnt_cyc + 1);
        mon_rw     = mon_access && q[0].rw;
      end
      chk("busy", busy, mon_busy);
      chk("ram_rw", ram_rw, mon_rw);
      if (mon_access) begin
        chk("ram_addr", ram_addr, q[0].addr);
        if (q[0].rw) chk("ram_wdata", ram_wdata, q[0].wdata);
      end
      if (m0_ack && m1_ack) fail_evt("ack_overlap");
      if (m0_ack || m1_ack) begin
        if (q.size() == 0) begin
          fail_evt("unexpected_ack");
        end else begin
          mon_e = q.pop_front();
          chk("ack_master", m1_ack, mon_e.m);
          chk("ack_cycle", cyc, mon_e.ack_cyc);
          if (!mon_e.rw) exp_rd[mon_e.m] = mon_e.rdata;
        end
      end else if (q.size() > 0 && cyc >= q[0].ack_cyc) begin
        fail_evt("ack_missing");
        q.delete(0);
      end
      chk("m0_rdata", m0_rdata, exp_rd[0]);
      chk("m1_rdata", m1_rdata, exp_rd[1]);
    end
  end

  task automatic set_m(input bit m, input logic req, input logic rw,
                       input logic [15:0] a, input logic [15:0] d);
    if (m) begin
      m1_req = req; m1_rw = rw; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = req; m0_rw = rw; m0_addr = a; m0_wdata = d;
    end
  endtask

  task automatic run_master(input bit m, input int n);
    bit keep;
    int k;
    int gap;
    keep = 1'b0;
    for (int t = 0; t < n; t++) begin
      if (t > 0 && !keep) begin
        set_m(m, 1'b0, 1'b0, 16'h0, 16'h0);
        gap = $urandom_range(0, 3);
        repeat (gap) begin @(posedge clock); #1; end
      end
      set_m(m, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      k = 0;
      do begin
        @(posedge clock); #1;
        k++;
      end while (!(m ? m1_ack : m0_ack) && k < 100);
      if (k >= 100) begin
        fail_evt(m ? "m1_ack_timeout" : "m0_ack_timeout");
        break;
      end
      keep = 1'($urandom_range(0, 1));
    end
    set_m(m, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic check_reset_values();
    chk("rst_busy", busy, 0);
    chk("rst_ram_rw", ram_rw, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ram_mem[i] = 16'(i * 16'h1111) ^ 16'h00AA;
      mdl_mem[i] = 16'(i * 16'h1111) ^ 16'h00AA;
    end
    for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    repeat (3) @(posedge clock);
    #1;
    check_reset_values();
    reset     = 1'b0;
    next_idle = cyc;
    run_model = 1'b1;

    // both masters start together so the first grant exercises the reset pointer
    fork
      run_master(1'b0, N_TXN);
      run_master(1'b1, N_TXN);
    join
    repeat (RD_LAT + 4) begin @(posedge clock); #1; end
    chk("queue_drained", q.size(), 0);

    // abort an m1 read while it is waiting for RAM data
    set_m(1'b1, 1'b1, 1'b0, 16'h1234, 16'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("busy_before_abort", busy, 1);
    run_model = 1'b0;
    q.delete();
    reset = 1'b1;
    set_m(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clock); #1;
    check_reset_values();
    reset     = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    ptr       = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      chk("abort_m1_ack", m1_ack, 0);
      chk("abort_ram_rw", ram_rw, 0);
      chk("abort_busy", busy, 0);
    end

    next_idle = cyc;
    run_model = 1'b1;
    fork
      run_master(1'b0, 6);
      run_master(1'b1, 6);
    join
    repeat (RD_LAT + 4) begin @(posedge clock); #1; end
    chk("queue_drained_2", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning RAM data width.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning RAM read latency in clocks (range 1-4).
REQ-004 SHALL have port clock  in  1  single clock for all logic (RAM clock domain).
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports m0_req / m1_req  in  1  access request from master 0 (CPU) / master 1 (video/debug).
REQ-007 SHALL have ports m0_rw / m1_rw  in  1  access type; 1 = write, 0 = read.
REQ-008 SHALL have ports m0_addr / m1_addr  in  ADDR_W  access address.
REQ-009 SHALL have ports m0_wdata / m1_wdata  in  DATA_W  write data.
REQ-010 SHALL have ports m0_ack / m1_ack  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports m0_rdata / m1_rdata  out  DATA_W  read data; valid with ack.
REQ-012 SHALL have port ram_addr  out  ADDR_W  RAM address.
REQ-013 SHALL have port ram_wdata  out  DATA_W  RAM write data.
REQ-014 SHALL have port ram_rw  out  1  RAM write enable, 1 = write.
REQ-015 SHALL have port ram_rdata  in  DATA_W  RAM read data.
REQ-016 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, WAIT, DONE; all outputs registered.
REQ-018 In IDLE with any req high, SHALL select one master, latch its rw/addr/wdata, and enter ACCESS next cycle; no req -> stay IDLE.
REQ-019 Arbitration SHALL be round-robin: a priority pointer names the preferred master; after a transaction completes, the pointer names the other master.
REQ-020 On simultaneous m0_req and m1_req, SHALL grant the pointer's master; a single requester SHALL be granted regardless of pointer.
REQ-021 In ACCESS (exactly 1 cycle), SHALL drive ram_addr/ram_wdata from the latched values; ram_rw = latched rw.
REQ-022 ram_rw SHALL be 0 in every state except ACCESS-for-a-write.
REQ-023 ram_addr and ram_wdata SHALL hold their last latched values outside ACCESS.
REQ-024 For a write: ACCESS -> DONE. For a read: ACCESS -> WAIT for RD_LAT cycles (down-counter) -> DONE.
REQ-025 SHALL capture ram_rdata on the last WAIT cycle into the granted master's rdata register.
REQ-026 In DONE, SHALL pulse the granted master's ack for exactly 1 cycle, update the pointer, and return to IDLE.
REQ-027 Latency from IDLE cycle N sampling req SHALL be: write ack in cycle N+2; read ack in cycle N+2+RD_LAT.
REQ-028 Requesters SHALL hold req/rw/addr/wdata stable until ack; inputs changing after the grant SHALL NOT affect the transaction.
REQ-029 req still high in the cycle after ack SHALL be treated as a new request (back-to-back), subject to REQ-019/020.
REQ-030 m*_rdata SHALL hold its value until the next read completes for that master; writes SHALL NOT modify it.
REQ-031 The non-granted master's ack SHALL stay 0 for the whole transaction.

Reset
REQ-032 On reset: state = IDLE, pointer = master 0, ram_rw = 0, ram_addr = 0, ram_wdata = 0, both acks = 0, both rdata = 0, busy = 0.
REQ-033 Reset mid-transaction SHALL abort it with no ack issued and no RAM write after the reset cycle.

Verification
REQ-034 m0 write addr 0x0010 data 0xBEEF in cycle N -> ram_rw = 1 only in cycle N+1, m0_ack in N+2; then m0 read 0x0010 -> m0_rdata = 0xBEEF with ack (RD_LAT=1, 3 cycles after req sampling).
REQ-035 m0_req and m1_req raised together after reset, held continuously -> grants alternate m0, m1, m0, m1; no ack ever overlaps.
REQ-036 m1 alone requests for 4 back-to-back reads -> m1 served each time, pointer irrelevant, zero idle-cycle gaps beyond IDLE.
REQ-037 Reset asserted in the WAIT state of an m1 read -> no m1_ack, all outputs at reset values next cycle, busy = 0.
REQ-038 RD_LAT = 3 read of 0x1234 holding 0x00AA -> m0_ack exactly 5 cycles after req sampled, m0_rdata = 0x00AA; m1_rdata unchanged.
